// File: rtl/trans_pkg.sv
// Constants and state encoding shared by the serial link transmitter and receiver.
package trans_pkg;

  localparam int DATA_W   = 55;
  localparam int HDR_ONES = 5;
  localparam int HDR_W    = HDR_ONES + 1;
  localparam int PKT_LEN  = HDR_W + DATA_W;
  localparam int CNT_W    = 6;

  localparam logic [HDR_W-1:0] HDR = 6'b01_1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/recv_protocol_shift_reg.sv
// Payload shift register. Holds the W-1 most recent line bits; the parallel
// word appends the live line bit so the full payload is available on the completion edge.
module rx_shift_reg #(
  parameter int W = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] word
);

  logic [W-2:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[W-3:0], din};
    end
  end

  assign word = {q, din};

endmodule

// File: rtl/recv_protocol.sv
// Serial packet receiver: detects the 01_1111 header, shifts in the payload MSB
// first and hands it to the router core over a valid/ack handshake.
//
// state   | meaning
// IDLE    | line idle, waiting for a start 0
// HDR     | counting the header ones after a start bit
// DATA    | shifting in payload bits
import trans_pkg::*;

module recv_protocol #(
  parameter int DATA_W   = trans_pkg::DATA_W,
  parameter int HDR_ONES = trans_pkg::HDR_ONES,
  parameter int CNT_W    = trans_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_Data,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] RX_Data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              rx_overrun,
  output logic              busy
);

  rx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               shift_en;
  logic               complete;
  logic               hdr_err;
  logic [DATA_W-1:0]  word;

  rx_shift_reg #(.W(DATA_W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (S_Data),
    .word     (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    complete  = 1'b0;
    hdr_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!S_Data) begin
          state_nxt = ST_HDR;
          cnt_nxt   = CNT_W'(HDR_ONES);
        end
      end
      ST_HDR: begin
        if (S_Data) begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = ST_DATA;
            cnt_nxt   = CNT_W'(DATA_W);
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end else begin
          // a premature 0 restarts the header rather than dropping to IDLE
          hdr_err = 1'b1;
          cnt_nxt = CNT_W'(HDR_ONES);
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RX_Data    <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_err     <= hdr_err;
      rx_overrun <= 1'b0;
      if (complete) begin
        // an unconsumed word wins over the new packet
        if (!rx_valid || rx_ack) begin
          RX_Data  <= word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
